// File: rtl/mux_pkg.sv
// Shared encodings for the selector arbiter: FSM states and sel polarity.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant/handshake bundle between the requesters, the arbiter and the consumer of d.
interface mux_sel_arbiter_if #(
    parameter int unsigned CNT_W = 2
);
    logic             req_a;
    logic             req_b;
    logic             out_ready;
    logic             sel;
    logic             gnt_a;
    logic             gnt_b;
    logic             out_valid;
    logic [CNT_W-1:0] burst_cnt;

    modport master (
        input  req_a, req_b, out_ready,
        output sel, gnt_a, gnt_b, out_valid, burst_cnt
    );

    modport slave (
        output req_a, req_b, out_ready,
        input  sel, gnt_a, gnt_b, out_valid, burst_cnt
    );
endinterface

// File: rtl/mux_sel_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; winner uses the SEL_A/SEL_B encoding.
module mux_sel_arbiter_rr_pick2
    import mux_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic any_req_c,
    output logic win_c
);

    assign any_req_c = req_a | req_b;

    // On a tie the side that did not hold the last grant wins.
    assign win_c = (req_a & req_b) ? ~last_grant
                 : (req_a ? SEL_A : SEL_B);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin, burst-locked arbiter driving sel of the 2:1 selector plus the downstream valid.
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t           state;
    logic             last_grant;
    logic             sel_q;
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic [CNT_W-1:0] cnt_q;

    logic pick_any_c;
    logic pick_win_c;
    logic own_side_c;
    logic own_req_c;
    logic other_req_c;
    logic xfer_c;
    logic release_c;

    mux_sel_arbiter_rr_pick2 u_pick (
        .req_a      (bus.req_a),
        .req_b      (bus.req_b),
        .last_grant (last_grant),
        .any_req_c  (pick_any_c),
        .win_c      (pick_win_c)
    );

    // Owner-relative view of the requests so both grant states share one release path.
    assign own_side_c  = (state == GRANT_A) ? SEL_A : SEL_B;
    assign own_req_c   = (state == GRANT_A) ? bus.req_a : bus.req_b;
    assign other_req_c = (state == GRANT_A) ? bus.req_b : bus.req_a;

    assign bus.out_valid = ((state == GRANT_A) & bus.req_a) | ((state == GRANT_B) & bus.req_b);
    assign xfer_c        = bus.out_valid & bus.out_ready;
    assign release_c     = (xfer_c && (cnt_q == LAST_CNT)) || !own_req_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SEL_B;
            sel_q      <= SEL_B;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any_c) begin
                        state   <= (pick_win_c == SEL_A) ? GRANT_A : GRANT_B;
                        sel_q   <= pick_win_c;
                        gnt_a_q <= (pick_win_c == SEL_A);
                        gnt_b_q <= (pick_win_c == SEL_B);
                        cnt_q   <= '0;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (release_c) begin
                        last_grant <= own_side_c;
                        cnt_q      <= '0;
                        if (other_req_c) begin
                            // Hand over directly, no idle bubble between bursts.
                            state   <= (own_side_c == SEL_A) ? GRANT_B : GRANT_A;
                            sel_q   <= ~own_side_c;
                            gnt_a_q <= (own_side_c == SEL_B);
                            gnt_b_q <= (own_side_c == SEL_A);
                        end else if (!own_req_c) begin
                            state   <= IDLE;
                            gnt_a_q <= 1'b0;
                            gnt_b_q <= 1'b0;
                        end
                    end else if (xfer_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.burst_cnt = cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: BURST_LEN=4 and BURST_LEN=1 instances share inputs and are
// compared every cycle against an ownership/burst reference model.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic ra, rb, rdy;

    always #5 clk = ~clk;

    mux_sel_arbiter_if #(.CNT_W(2)) bus4 ();
    mux_sel_arbiter_if #(.CNT_W(1)) bus1 ();

    assign bus4.req_a     = ra;
    assign bus4.req_b     = rb;
    assign bus4.out_ready = rdy;
    assign bus1.req_a     = ra;
    assign bus1.req_b     = rb;
    assign bus1.out_ready = rdy;

    mux_sel_arbiter #(.BURST_LEN(4), .CNT_W(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    mux_sel_arbiter #(.BURST_LEN(1), .CNT_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: owner 0=none 1=A 2=B, transfers done in burst, last owner, sel level.
    int   owner [2];
    int   cnt   [2];
    int   last  [2];
    logic msel  [2];
    int   bl    [2] = '{4, 1};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_valid(input int i);
        return (owner[i] == 1) ? ra : ((owner[i] == 2) ? rb : 1'b0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = 0;
            cnt[i]   = 0;
            last[i]  = 2;
            msel[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        logic own_req, oth_req, xfer;
        if (rst) begin
            owner[i] = 0; cnt[i] = 0; last[i] = 2; msel[i] = 1'b0;
        end else if (owner[i] == 0) begin
            if (ra || rb) begin
                owner[i] = (ra && rb) ? (3 - last[i]) : (ra ? 1 : 2);
                msel[i]  = (owner[i] == 1);
                cnt[i]   = 0;
            end
        end else begin
            own_req = (owner[i] == 1) ? ra : rb;
            oth_req = (owner[i] == 1) ? rb : ra;
            xfer    = exp_valid(i) && rdy;
            if ((xfer && cnt[i] == bl[i] - 1) || !own_req) begin
                last[i] = owner[i];
                cnt[i]  = 0;
                if (oth_req)       owner[i] = 3 - owner[i];
                else if (!own_req) owner[i] = 0;
                if (owner[i] != 0) msel[i] = (owner[i] == 1);
            end else if (xfer) begin
                cnt[i] = cnt[i] + 1;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt_a4", 8'(bus4.gnt_a),     8'(owner[0] == 1));
        chk("gnt_b4", 8'(bus4.gnt_b),     8'(owner[0] == 2));
        chk("sel4",   8'(bus4.sel),       8'(msel[0]));
        chk("cnt4",   8'(bus4.burst_cnt), 8'(cnt[0]));
        chk("valid4", 8'(bus4.out_valid), 8'(exp_valid(0)));
        chk("gnt_a1", 8'(bus1.gnt_a),     8'(owner[1] == 1));
        chk("gnt_b1", 8'(bus1.gnt_b),     8'(owner[1] == 2));
        chk("sel1",   8'(bus1.sel),       8'(msel[1]));
        chk("cnt1",   8'(bus1.burst_cnt), 8'(cnt[1]));
        chk("valid1", 8'(bus1.out_valid), 8'(exp_valid(1)));
    endtask

    // Check before the edge, then advance the model across it.
    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_all();
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic b, input logic y);
        rst = r; ra = a; rb = b; rdy = y;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        cycle(2);
        chk("rst_sel",   8'(bus4.sel),   8'h00);
        chk("rst_gnt_a", 8'(bus4.gnt_a), 8'h00);

        // Lone requester A: grant one cycle later, re-grant after 4 transfers.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1);
        chk("a_first_gnt", 8'(bus4.gnt_a), 8'h01);
        chk("a_first_sel", 8'(bus4.sel),   8'h01);
        cycle(9);

        // Contention from reset: A, B, A bursts back to back.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(14);

        // Stall with out_ready low, then resume.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(6);
        chk("stall_cnt", 8'(bus4.burst_cnt), 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(3);

        // A mid-burst with B waiting, A drops.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(3);

        // Reset mid-burst, then a tie must go to A.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(4);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(2);
        chk("tie_after_rst", 8'(bus4.gnt_a), 8'h01);
        cycle(6);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            cycle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
